// File: rtl/rv32i_pkg.sv
// Shared types for the data-cache port arbiter: datapath width, arbiter
// state encoding and the loader FIFO entry layout.
package rv32i_pkg;

  localparam int DPW = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [DPW-1:0] addr;
    logic [DPW-1:0] data;
  } ldr_entry_t;

endpackage

// File: rtl/dcarb_ldr_fifo.sv
// Synchronous FIFO of loader writes. Exposes every slot plus a per-slot valid
// vector so the arbiter can compare all pending addresses at once.
module dcarb_ldr_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     push,
  input  logic                     pop,
  input  ldr_entry_t               wrEntry,
  output logic                     full,
  output logic                     empty,
  output ldr_entry_t               head,
  output ldr_entry_t [DEPTH-1:0]   entries,
  output logic [DEPTH-1:0]         validVec
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wrPtr, rdPtr;
  ldr_entry_t [DEPTH-1:0] mem;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      validVec <= '0;
    end else begin
      if (push) begin
        wrPtr                  <= wrPtr + PtrOne;
        validVec[wrPtr[AW-1:0]] <= 1'b1;
      end
      if (pop) begin
        rdPtr                  <= rdPtr + PtrOne;
        validVec[rdPtr[AW-1:0]] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= wrEntry;
  end

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign head    = mem[rdPtr[AW-1:0]];
  assign entries = mem;

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single-port data cache between the Memory stage and the
// buffered external loader. Define DCARB_PERF_EN to add stall/force counters.
module dcache_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int LDR_DEPTH = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic           clk,
  input  logic           arst,
  input  logic           boot_done,
  input  logic           ldr_valid,
  input  logic [DPW-1:0] ldr_addr,
  input  logic [DPW-1:0] ldr_data,
  output logic           ldr_ready,
  output logic           ldr_overflow,
  input  logic           m_req,
  input  logic           m_we,
  input  logic [DPW-1:0] m_addr,
  input  logic [DPW-1:0] m_wdata,
  output logic           m_stall,
  output logic           dc_en,
  output logic           dc_we,
  output logic [DPW-1:0] dc_addr,
  output logic [DPW-1:0] dc_wdata,
  output logic [1:0]     arb_state
`ifdef DCARB_PERF_EN
  ,
  output logic [31:0]    perf_stall_cnt,
  output logic [15:0]    perf_force_cnt
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CntMax = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CntOne = CW'(1);

  arb_state_t state, stateNext;
  logic [CW-1:0] starveCnt;
  logic fifoFull, fifoEmpty, push, hazard, starved, loaderGrant, pipeGrant;
  ldr_entry_t ldrEntry, head;
  ldr_entry_t [LDR_DEPTH-1:0] entries;
  logic [LDR_DEPTH-1:0] validVec;

  assign ldrEntry.addr = ldr_addr;
  assign ldrEntry.data = ldr_data;
  assign ldr_ready     = !fifoFull;
  assign push          = ldr_valid && !fifoFull;
  assign arb_state     = state;

  dcarb_ldr_fifo #(.DEPTH(LDR_DEPTH)) uFifo (
    .clk      (clk),
    .arst     (arst),
    .push     (push),
    .pop      (loaderGrant),
    .wrEntry  (ldrEntry),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .head     (head),
    .entries  (entries),
    .validVec (validVec)
  );

  // A pipeline access to a word still queued must wait for the loader write.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LDR_DEPTH; i++) begin
      if (validVec[i] && (entries[i].addr[DPW-1:2] == m_addr[DPW-1:2])) hazard = 1'b1;
    end
    hazard = hazard && m_req && !fifoEmpty;
  end

  assign starved = !fifoEmpty && (starveCnt == CntMax);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= BOOT;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      BOOT:    if (boot_done) stateNext = DRAIN;
      DRAIN:   if (fifoEmpty && !push) stateNext = RUN;
      RUN:     stateNext = RUN;
      default: stateNext = BOOT;
    endcase
  end

  always_comb begin
    loaderGrant = 1'b0;
    pipeGrant   = 1'b0;
    m_stall     = 1'b1;
    dc_en       = 1'b0;
    dc_we       = 1'b0;
    dc_addr     = '0;
    dc_wdata    = '0;
    case (state)
      BOOT, DRAIN: loaderGrant = !fifoEmpty;
      RUN: begin
        loaderGrant = !fifoEmpty && (starved || hazard || !m_req);
        pipeGrant   = m_req && !loaderGrant;
        m_stall     = m_req && loaderGrant;
      end
      default: ;
    endcase
    if (loaderGrant) begin
      dc_en    = 1'b1;
      dc_we    = 1'b1;
      dc_addr  = head.addr;
      dc_wdata = head.data;
    end else if (pipeGrant) begin
      dc_en    = 1'b1;
      dc_we    = m_we;
      dc_addr  = m_addr;
      dc_wdata = m_wdata;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                                           starveCnt <= '0;
    else if (state != RUN || fifoEmpty || loaderGrant)  starveCnt <= '0;
    else if (starveCnt != CntMax)                       starveCnt <= starveCnt + CntOne;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                       ldr_overflow <= 1'b0;
    else if (ldr_valid && fifoFull) ldr_overflow <= 1'b1;
  end

`ifdef DCARB_PERF_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      perf_stall_cnt <= '0;
      perf_force_cnt <= '0;
    end else if (state == RUN) begin
      if (m_req && m_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (starved)          perf_force_cnt <= perf_force_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed scenarios plus randomized traffic for dcache_port_arbiter, checked
// cycle by cycle against a queue-based behavioural model.
module tb_dcache_port_arbiter;
  import rv32i_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXW  = 8;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic boot_done = 1'b0, ldr_valid = 1'b0, m_req = 1'b0, m_we = 1'b0;
  logic [31:0] ldr_addr = '0, ldr_data = '0, m_addr = '0, m_wdata = '0;
  logic ldr_ready, ldr_overflow, m_stall, dc_en, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic [1:0] arb_state;
`ifdef DCARB_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_force_cnt;
`endif

  always #5 clk = ~clk;

  dcache_port_arbiter #(.LDR_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .arst(arst), .boot_done(boot_done),
    .ldr_valid(ldr_valid), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
    .ldr_ready(ldr_ready), .ldr_overflow(ldr_overflow),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_stall(m_stall), .dc_en(dc_en), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .arb_state(arb_state)
`ifdef DCARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_force_cnt(perf_force_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: 0=boot 1=drain 2=run, queue of pending loader writes.
  int mState, starve, perfStall, perfForce;
  bit ovf;
  logic [31:0] qAddr[$];
  logic [31:0] qData[$];
  bit eLg, ePg, eStall, eEn, eWe;
  logic [31:0] eAddr, eData;

  task automatic modelReset();
    mState = 0; starve = 0; ovf = 0; perfStall = 0; perfForce = 0;
    qAddr.delete(); qData.delete();
  endtask

  task automatic evalModel();
    bit haz;
    bit ne;
    haz = 0;
    ne = (qAddr.size() != 0);
    foreach (qAddr[i]) if (qAddr[i][31:2] == m_addr[31:2]) haz = 1;
    haz = haz && m_req;
    if (mState != 2) begin
      eLg = ne; eStall = 1;
    end else begin
      eLg = ne && (starve == MAXW || haz || !m_req);
      eStall = m_req && eLg;
    end
    ePg = (mState == 2) && m_req && !eLg;
    eEn = eLg || ePg;
    eWe = eLg ? 1'b1 : (ePg && m_we);
    eAddr = m_addr; eData = m_wdata;
    if (eLg) begin eAddr = qAddr[0]; eData = qData[0]; end
  endtask

  task automatic checkOutputs();
    evalModel();
    checkVal("m_stall", m_stall, eStall);
    checkVal("dc_en", dc_en, eEn);
    checkVal("dc_we", dc_we, eWe);
    if (eEn) begin
      checkVal("dc_addr", dc_addr, eAddr);
      checkVal("dc_wdata", dc_wdata, eData);
    end
    checkVal("arb_state", arb_state, mState);
    checkVal("ldr_ready", ldr_ready, qAddr.size() < DEPTH);
    checkVal("ldr_overflow", ldr_overflow, ovf);
`ifdef DCARB_PERF_EN
    checkVal("perf_stall_cnt", perf_stall_cnt, 32'(perfStall));
    checkVal("perf_force_cnt", perf_force_cnt, 16'(perfForce));
`endif
  endtask

  task automatic updateModel();
    bit ne, ready, push;
    ne = (qAddr.size() != 0);
    ready = (qAddr.size() < DEPTH);
    push = ldr_valid && ready;
    if (ldr_valid && !ready) ovf = 1;
    if (mState == 2) begin
      if (m_req && eStall) perfStall++;
      if (ne && starve == MAXW) perfForce++;
    end
    if (mState == 2 && ne && !eLg) starve = (starve < MAXW) ? starve + 1 : MAXW;
    else starve = 0;
    if (mState == 0 && boot_done) mState = 1;
    else if (mState == 1 && !ne && !push) mState = 2;
    if (eLg) begin void'(qAddr.pop_front()); void'(qData.pop_front()); end
    if (push) begin qAddr.push_back(ldr_addr); qData.push_back(ldr_data); end
  endtask

  task automatic cycle();
    #1;
    checkOutputs();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic resetDut();
    arst = 1'b1;
    boot_done = 0; ldr_valid = 0; m_req = 0; m_we = 0;
    ldr_addr = '0; ldr_data = '0; m_addr = '0; m_wdata = '0;
    modelReset();
    #1;
    checkOutputs();
    @(negedge clk);
    arst = 1'b0;
  endtask

  logic [31:0] tA [3] = '{32'h10, 32'h14, 32'h18};
  logic [31:0] tD [3] = '{32'hA, 32'hB, 32'hC};
  logic [31:0] wA[$];
  logic [31:0] wD[$];
  int pipeCnt, found, wrCnt;

  initial begin
    @(negedge clk);
    resetDut();
    checkVal("rst_dc_addr", dc_addr, 0);
    checkVal("rst_dc_wdata", dc_wdata, 0);

    // Boot preload: three loader writes issued in order, then DRAIN -> RUN.
    for (int c = 0; c < 10; c++) begin
      ldr_valid = (c < 3);
      if (c < 3) begin ldr_addr = tA[c]; ldr_data = tD[c]; end
      boot_done = (c >= 2);
      #1;
      if (dc_en && dc_we) begin wA.push_back(dc_addr); wD.push_back(dc_wdata); end
      cycle();
    end
    checkVal("boot_nwr", wA.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wA.size()) begin
        checkVal($sformatf("boot_addr%0d", i), wA[i], tA[i]);
        checkVal($sformatf("boot_data%0d", i), wD[i], tD[i]);
      end
    end
    checkVal("boot_in_run", arb_state, 2);

    // Starvation: loader entry waits MAX_WAIT pipeline grants then is forced.
    resetDut();
    boot_done = 1;
    cycle();
    cycle();
    checkVal("starve_run", arb_state, 2);
    m_req = 1; m_we = 0; m_addr = 32'h80;
    ldr_valid = 1; ldr_addr = 32'h40; ldr_data = 32'h55;
    cycle();
    ldr_valid = 0;
    pipeCnt = 0; found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      #1;
      if (dc_en && dc_we && dc_addr == 32'h40) begin
        found = 1;
        checkVal("starve_stall", m_stall, 1);
      end else if (dc_en && !dc_we && dc_addr == 32'h80) pipeCnt++;
      cycle();
    end
    checkVal("starve_found", found, 1);
    checkVal("starve_pipe_grants", pipeCnt, MAXW);
`ifdef DCARB_PERF_EN
    checkVal("perf_force_once", perf_force_cnt, 1);
    checkVal("perf_stall_once", perf_stall_cnt, 1);
`endif
    #1;
    checkVal("starve_after_stall", m_stall, 0);
    cycle();

    // Ordering hazard: load to a queued word waits for the loader write.
    m_req = 0;
    ldr_valid = 1; ldr_addr = 32'h100; ldr_data = 32'h77;
    cycle();
    ldr_valid = 0; m_req = 1; m_we = 0; m_addr = 32'h102;
    #1;
    checkVal("hz_stall", m_stall, 1);
    checkVal("hz_ldr_addr", dc_addr, 32'h100);
    checkVal("hz_ldr_we", dc_we, 1);
    cycle();
    #1;
    checkVal("hz_load_stall", m_stall, 0);
    checkVal("hz_load_addr", dc_addr, 32'h102);
    checkVal("hz_load_we", dc_we, 0);
    cycle();

    // Overflow: five pushes into a four-entry FIFO while the pipeline holds the port.
    m_req = 1; m_addr = 32'h80;
    for (int c = 0; c < 5; c++) begin
      ldr_valid = 1; ldr_addr = 32'h200 + 32'(16 * c); ldr_data = 32'(c);
      #1;
      if (c == 3) checkVal("ready_before_full", ldr_ready, 1);
      if (c == 4) checkVal("full_not_ready", ldr_ready, 0);
      cycle();
    end
    ldr_valid = 0;
    #1;
    checkVal("ovf_set", ldr_overflow, 1);
    m_req = 0;
    for (int c = 0; c < 6; c++) cycle();
    checkVal("ovf_sticky", ldr_overflow, 1);
    checkVal("drained_ready", ldr_ready, 1);

    // Async reset with two writes queued: FIFO discarded immediately.
    m_req = 1; m_addr = 32'h80;
    for (int c = 0; c < 2; c++) begin
      ldr_valid = 1; ldr_addr = 32'h300 + 32'(4 * c); ldr_data = 32'h9 + 32'(c);
      cycle();
    end
    ldr_valid = 0; m_req = 0;
    #1;
    checkVal("pre_rst_en", dc_en, 1);
    arst = 1;
    modelReset();
    #1;
    checkVal("arst_dc_en", dc_en, 0);
    checkVal("arst_state", arb_state, 0);
    checkVal("arst_ready", ldr_ready, 1);
    checkVal("arst_stall", m_stall, 1);
    @(negedge clk);
    arst = 0;
    boot_done = 1;
    wrCnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (dc_en) wrCnt++;
      cycle();
    end
    checkVal("arst_no_writes", wrCnt, 0);

    // Randomized traffic over a small address pool to provoke hazards and full FIFO.
    resetDut();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) resetDut();
      boot_done = ((c % 300) > 12) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ldr_valid = ($urandom_range(0, 99) < 45);
      ldr_addr = 32'h1000 + 32'($urandom_range(0, 7) << 2);
      ldr_data = $urandom;
      m_req = ($urandom_range(0, 99) < 70);
      m_we = $urandom_range(0, 1) != 0;
      m_addr = 32'h1000 + 32'($urandom_range(0, 40));
      m_wdata = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
